// File: rtl/vtiming_pkg.sv
// Default raster timing constants and the sync window compare.
// Shared by video_timing_gen and its counters.
package vtiming_pkg;

    localparam int W_DEF        = 9;
    localparam int H_TOTAL_DEF  = 337;
    localparam int H_ACTIVE_DEF = 240;
    localparam int HS_START_DEF = 240;
    localparam int HS_END_DEF   = 280;
    localparam int V_TOTAL_DEF  = 262;
    localparam int V_ACTIVE_DEF = 240;
    localparam int VS_START_DEF = 244;
    localparam int VS_END_DEF   = 247;
    localparam int IRQ_HPOS_DEF = 331;
    localparam int IRQ_LOG2_DEF = 3;

    // True when cnt lies in [start, stop); a window whose start is past
    // its stop has wrapped around the end of the line or frame.
    function automatic logic in_window(
        input logic [15:0] cnt,
        input logic [15:0] start,
        input logic [15:0] stop
    );
        if (start <= stop)
            return (cnt >= start) && (cnt < stop);
        else
            return (cnt >= start) || (cnt < stop);
    endfunction

endpackage

// File: rtl/vtiming_counter.sv
// W-bit wrap counter with enable and terminal-count flag.
// Exposes its next value so callers can register zero-latency decodes.
module vtiming_counter #(
    parameter int W     = 9,
    parameter int TOTAL = 337
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    assign tc = (cnt == LAST);

    // Next count: advance on enable, wrapping to zero after the last value
    always_comb begin
        nxt = cnt;
        if (en)
            nxt = tc ? '0 : cnt + W'(1);
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= nxt;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, blank, flip counters, irqs.
// Define VTIMING_SHIFT_EN to add hshift/vshift sync-window centring.
module video_timing_gen
    import vtiming_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int IRQ_HPOS = IRQ_HPOS_DEF,
    parameter int IRQ_LOG2 = IRQ_LOG2_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_pix,
    input  logic         flip,
`ifdef VTIMING_SHIFT_EN
    input  logic [3:0]   hshift,
    input  logic [3:0]   vshift,
`endif
    output logic [W-1:0] hcount,
    output logic [W-1:0] vcount,
    output logic [W-1:0] hcount_f,
    output logic [W-1:0] vcount_f,
    output logic         hs,
    output logic         vs,
    output logic         hb,
    output logic         vb,
    output logic         de,
    output logic         nmi,
    output logic         irq,
    output logic         frame_start
);

    if (W > 16) begin : g_bad_w
        $error("W must not exceed 16");
    end
    if (H_TOTAL > (1 << W) || V_TOTAL > (1 << W)) begin : g_bad_tot
        $error("H_TOTAL and V_TOTAL must fit in W bits");
    end
    if (HS_START >= HS_END) begin : g_bad_hs
        $error("HS_START must be below HS_END");
    end
    if (VS_START >= VS_END) begin : g_bad_vs
        $error("VS_START must be below VS_END");
    end
    if (H_ACTIVE >= H_TOTAL) begin : g_bad_ha
        $error("H_ACTIVE must be below H_TOTAL");
    end
    if (V_ACTIVE >= V_TOTAL) begin : g_bad_va
        $error("V_ACTIVE must be below V_TOTAL");
    end
    if (IRQ_HPOS >= H_TOTAL) begin : g_bad_irq
        $error("IRQ_HPOS must be below H_TOTAL");
    end
    if (IRQ_LOG2 < 1 || IRQ_LOG2 > W) begin : g_bad_log2
        $error("IRQ_LOG2 must be in 1..W");
    end

    localparam logic [W-1:0] HA    = W'(H_ACTIVE);
    localparam logic [W-1:0] VA    = W'(V_ACTIVE);
    localparam logic [W-1:0] IRQ_H = W'(IRQ_HPOS);

    logic [W-1:0] h_nxt;
    logic [W-1:0] v_nxt;
    logic         h_tc;
    logic         v_tc;
    logic         v_en;
    logic         wrap;

    assign v_en = ce_pix & h_tc;
    assign wrap = ce_pix & h_tc & v_tc;

    vtiming_counter #(
        .W     (W),
        .TOTAL (H_TOTAL)
    ) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .en    (ce_pix),
        .cnt   (hcount),
        .nxt   (h_nxt),
        .tc    (h_tc)
    );

    vtiming_counter #(
        .W     (W),
        .TOTAL (V_TOTAL)
    ) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .cnt   (vcount),
        .nxt   (v_nxt),
        .tc    (v_tc)
    );

    // Flip (and shift) take their new value on the edge that wraps to
    // (0,0), so the first pixel of the new frame already uses them.
    logic flip_q;
    logic flip_n;

    assign flip_n = wrap ? flip : flip_q;

    logic [W-1:0] hs_a;
    logic [W-1:0] hs_b;
    logic [W-1:0] vs_a;
    logic [W-1:0] vs_b;

`ifdef VTIMING_SHIFT_EN
    logic [3:0] hsh_q;
    logic [3:0] vsh_q;
    logic [3:0] hsh_n;
    logic [3:0] vsh_n;

    assign hsh_n = wrap ? hshift : hsh_q;
    assign vsh_n = wrap ? vshift : vsh_q;

    function automatic logic [W-1:0] shift_pos(
        input int         base,
        input logic [3:0] sh,
        input int         total
    );
        int p;
        p = base + int'($signed(sh));
        if (p < 0)
            p = p + total;
        else if (p >= total)
            p = p - total;
        return W'(p);
    endfunction

    assign hs_a = shift_pos(HS_START, hsh_n, H_TOTAL);
    assign hs_b = shift_pos(HS_END, hsh_n, H_TOTAL);
    assign vs_a = shift_pos(VS_START, vsh_n, V_TOTAL);
    assign vs_b = shift_pos(VS_END, vsh_n, V_TOTAL);

    // Shift values held for the whole frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsh_q <= '0;
            vsh_q <= '0;
        end else begin
            hsh_q <= hsh_n;
            vsh_q <= vsh_n;
        end
    end
`else
    assign hs_a = W'(HS_START);
    assign hs_b = W'(HS_END);
    assign vs_a = W'(VS_START);
    assign vs_b = W'(VS_END);
`endif

    logic         hs_n;
    logic         vs_n;
    logic         hb_n;
    logic         vb_n;
    logic         nmi_n;
    logic         irq_n;
    logic [W-1:0] hf_n;
    logic [W-1:0] vf_n;

    // Decode the next counter values so outputs line up with the counters
    always_comb begin
        hs_n  = ~in_window(16'(h_nxt), 16'(hs_a), 16'(hs_b));
        vs_n  = ~in_window(16'(v_nxt), 16'(vs_a), 16'(vs_b));
        hb_n  = (h_nxt >= HA);
        vb_n  = (v_nxt >= VA);
        nmi_n = (v_nxt == VA) && (h_nxt >= IRQ_H);
        irq_n = (&v_nxt[IRQ_LOG2-1:0]) && (h_nxt >= IRQ_H);
        hf_n  = (flip_n && !hb_n) ? HA - W'(1) - h_nxt : h_nxt;
        vf_n  = (flip_n && !vb_n) ? VA - W'(1) - v_nxt : v_nxt;
    end

    // Registered timing outputs; without ce_pix the next values equal
    // the current ones, so everything holds and frame_start drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_q      <= 1'b0;
            hcount_f    <= '0;
            vcount_f    <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            hb          <= 1'b0;
            vb          <= 1'b0;
            de          <= 1'b1;
            nmi         <= 1'b0;
            irq         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            flip_q      <= flip_n;
            hcount_f    <= hf_n;
            vcount_f    <= vf_n;
            hs          <= hs_n;
            vs          <= vs_n;
            hb          <= hb_n;
            vb          <= vb_n;
            de          <= ~hb_n & ~vb_n;
            nmi         <= nmi_n;
            irq         <= irq_n;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a position-based model.
// Uses a reduced raster so several whole frames fit in a short run.
module tb_video_timing_gen;

    localparam int BW  = 7;
    localparam int HT  = 50;
    localparam int HA  = 32;
    localparam int HSS = 36;
    localparam int HSE = 42;
    localparam int VT  = 40;
    localparam int VA  = 30;
    localparam int VSS = 32;
    localparam int VSE = 35;
    localparam int IH  = 45;
    localparam int IL  = 2;
    localparam int VW  = 4 * BW + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce_pix = 1'b0;
    logic          flip = 1'b0;
    logic [3:0]    hshift = 4'h0;
    logic [3:0]    vshift = 4'h0;
    logic [BW-1:0] hcount;
    logic [BW-1:0] vcount;
    logic [BW-1:0] hcount_f;
    logic [BW-1:0] vcount_f;
    logic          hs;
    logic          vs;
    logic          hb;
    logic          vb;
    logic          de;
    logic          nmi;
    logic          irq;
    logic          frame_start;

    int passed = 0;
    int total  = 0;

    int mh  = 0;
    int mv  = 0;
    bit mflip = 0;
    bit mfs = 0;
    int mhs = 0;
    int mvs = 0;

    video_timing_gen #(
        .W        (BW),
        .H_TOTAL  (HT),
        .H_ACTIVE (HA),
        .HS_START (HSS),
        .HS_END   (HSE),
        .V_TOTAL  (VT),
        .V_ACTIVE (VA),
        .VS_START (VSS),
        .VS_END   (VSE),
        .IRQ_HPOS (IH),
        .IRQ_LOG2 (IL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .flip        (flip),
`ifdef VTIMING_SHIFT_EN
        .hshift      (hshift),
        .vshift      (vshift),
`endif
        .hcount      (hcount),
        .vcount      (vcount),
        .hcount_f    (hcount_f),
        .vcount_f    (vcount_f),
        .hs          (hs),
        .vs          (vs),
        .hb          (hb),
        .vb          (vb),
        .de          (de),
        .nmi         (nmi),
        .irq         (irq),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {hcount, vcount, hcount_f, vcount_f,
                hs, vs, hb, vb, de, nmi, irq, frame_start};
    endfunction

    // Expected outputs from the raster position alone
    function automatic logic [VW-1:0] exp_vec();
        int h0, v0, hf, vf;
        bit e_hs, e_vs, e_hb, e_vb, e_de, e_nmi, e_irq;
        h0    = (((HSS + mhs) % HT) + HT) % HT;
        v0    = (((VSS + mvs) % VT) + VT) % VT;
        e_hs  = !(((mh - h0 + HT) % HT) < (HSE - HSS));
        e_vs  = !(((mv - v0 + VT) % VT) < (VSE - VSS));
        e_hb  = mh >= HA;
        e_vb  = mv >= VA;
        e_de  = !e_hb && !e_vb;
        e_nmi = (mv == VA) && (mh >= IH);
        e_irq = ((mv % (1 << IL)) == (1 << IL) - 1) && (mh >= IH);
        hf    = (mflip && mh < HA) ? HA - 1 - mh : mh;
        vf    = (mflip && mv < VA) ? VA - 1 - mv : mv;
        return {BW'(mh), BW'(mv), BW'(hf), BW'(vf),
                e_hs, e_vs, e_hb, e_vb, e_de, e_nmi, e_irq, mfs};
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mflip = 0;
        mfs = 0;
        mhs = 0;
        mvs = 0;
    endtask

    // One clock with the given enable; the model follows the same edge
    task automatic tick(input bit c);
        ce_pix = c;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            mfs = 0;
            if (c) begin
                if (mh == HT - 1) begin
                    mh = 0;
                    if (mv == VT - 1) begin
                        mv = 0;
                        mfs = 1;
                        mflip = flip;
                        mhs = int'($signed(hshift));
                        mvs = int'($signed(vshift));
                    end else begin
                        mv = mv + 1;
                    end
                end else begin
                    mh = mh + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0);
        tick(0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick(1);
        total++;
        if (dut_vec() !== exp_vec())
            $display("FAIL pre_reset got %h exp %h", dut_vec(), exp_vec());
        else
            passed++;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_vec() !== exp_vec())
            $display("FAIL async_reset got %h exp %h", dut_vec(), exp_vec());
        else
            passed++;
        tick(1);
        reset = 1'b0;
        tick(1);
        total++;
        if (hcount !== BW'(1) || dut_vec() !== exp_vec())
            $display("FAIL reset_release got h=%0d exp h=1", hcount);
        else
            passed++;
    endtask

    task automatic test_free_run();
        int fs_n = 0;
        int gap = 0;
        int hs_lo = 0;
        int vs_lo = 0;
        int irq_r = 0;
        int nmi_r = 0;
        bit pirq = 0;
        bit pnmi = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick(1);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL free_run h=%0d v=%0d got %h exp %h",
                         mh, mv, dut_vec(), exp_vec());
            else
                passed++;
            if (frame_start) fs_n++;
            if (fs_n == 1) begin
                gap++;
                if (!hs) hs_lo++;
                if (!vs) vs_lo++;
                if (irq && !pirq) irq_r++;
                if (nmi && !pnmi) nmi_r++;
            end
            pirq = irq;
            pnmi = nmi;
        end
        total++;
        if (fs_n !== 2)
            $display("FAIL frame_starts got %0d exp 2", fs_n);
        else
            passed++;
        total++;
        if (gap !== HT * VT)
            $display("FAIL frame_len got %0d exp %0d", gap, HT * VT);
        else
            passed++;
        total++;
        if (hs_lo !== VT * (HSE - HSS))
            $display("FAIL hs_low got %0d exp %0d", hs_lo, VT * (HSE - HSS));
        else
            passed++;
        total++;
        if (vs_lo !== HT * (VSE - VSS))
            $display("FAIL vs_low got %0d exp %0d", vs_lo, HT * (VSE - VSS));
        else
            passed++;
        total++;
        if (irq_r !== VT / (1 << IL))
            $display("FAIL irq_count got %0d exp %0d", irq_r, VT / (1 << IL));
        else
            passed++;
        total++;
        if (nmi_r !== 1)
            $display("FAIL nmi_count got %0d exp 1", nmi_r);
        else
            passed++;
    endtask

    task automatic test_ce_random();
        for (int i = 0; i < 4 * HT * VT + 500; i++) begin
            if ($urandom_range(0, 199) == 0) flip = $urandom_range(0, 1) == 1;
            tick($urandom_range(0, 3) == 0);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ce_random h=%0d v=%0d ce=%0d got %h exp %h",
                         mh, mv, ce_pix, dut_vec(), exp_vec());
            else
                passed++;
        end
    endtask

    task automatic test_flip();
        bit hit;
        flip = 1'b0;
        hit = 0;
        for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
            tick(1);
            hit = mfs;
        end
        hit = 0;
        for (int i = 0; i < HT * VT && !hit; i++) begin
            tick(1);
            hit = (mv == 10);
        end
        flip = 1'b1;
        hit = 0;
        for (int i = 0; i < HT * VT + 10 && !hit; i++) begin
            tick(1);
            hit = mfs;
            total++;
            if (dut_vec() !== exp_vec() || (!hit && hcount_f !== hcount))
                $display("FAIL flip_wait h=%0d v=%0d got %h exp %h",
                         mh, mv, dut_vec(), exp_vec());
            else
                passed++;
        end
        total++;
        if (!hit || hcount_f !== BW'(HA - 1) || vcount_f !== BW'(VA - 1))
            $display("FAIL flip_origin got hf=%0d vf=%0d exp %0d %0d",
                     hcount_f, vcount_f, HA - 1, VA - 1);
        else
            passed++;
        flip = 1'b0;
        for (int i = 0; i < HA + 3; i++) begin
            tick(1);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL flip_line h=%0d got %h exp %h",
                         mh, dut_vec(), exp_vec());
            else
                passed++;
        end
        total++;
        if (hcount_f !== BW'(HA + 3) || vcount_f !== BW'(VA - 1))
            $display("FAIL flip_blank got hf=%0d vf=%0d exp %0d %0d",
                     hcount_f, vcount_f, HA + 3, VA - 1);
        else
            passed++;
        hit = 0;
        for (int i = 0; i < HT * VT + 10 && !hit; i++) begin
            tick(1);
            hit = mfs;
        end
        total++;
        if (!hit || hcount_f !== BW'(0) || vcount_f !== BW'(0))
            $display("FAIL flip_off got hf=%0d vf=%0d exp 0 0",
                     hcount_f, vcount_f);
        else
            passed++;
    endtask

`ifdef VTIMING_SHIFT_EN
    task automatic test_shift();
        hshift = 4'hE;
        vshift = 4'h1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick(1);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL shift_fixed h=%0d v=%0d got %h exp %h",
                         mh, mv, dut_vec(), exp_vec());
            else
                passed++;
        end
        for (int i = 0; i < 3 * HT * VT; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                hshift = 4'($urandom_range(0, 15));
                vshift = 4'($urandom_range(0, 15));
            end
            tick($urandom_range(0, 1) == 1);
            total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL shift_random h=%0d v=%0d got %h exp %h",
                         mh, mv, dut_vec(), exp_vec());
            else
                passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_ce_random();
        test_flip();
`ifdef VTIMING_SHIFT_EN
        test_shift();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
